cpu_run_ctrl: RTL and testbench

Run controller that sits directly upstream of the `CPU` core and drives its `start` input from a raw board push-button. It synchronizes and debounces the button, issues a single-cycle `start` pulse, and tracks the core's `stopped` handshake. It also reports the program run length in clock cycles and flags a core that never acknowledges or never halts.

---
 rtl/cpu_run_ctrl.sv | 148 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: launches the CPU core from a debounced push-button and tracks its run.
//   Ports: clk/reset (sync, active-high); btn_in raw button; stopped from CPU;
//          start pulse to CPU; busy/done/fault status; cycle_count run length.
//   Optional run-length watchdog built only when RUN_WATCHDOG_EN is defined.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int ACK_TIMEOUT     = 8,
  parameter int WDOG_CYCLES     = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_in,
  input  logic             stopped,
  output logic             start,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACK,
    S_RUNNING,
    S_DONE
  } state_t;

  // ---------------- input path ----------------
  logic            sync1, sync2;
  logic            btn_db, btn_db_d;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  // press is registered off the btn_db edge, so an accepted level change
  // reaches LAUNCH one edge after press: sync(2) + debounce(N) + press(1) + FSM(1).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      if (sync2 != btn_db) begin
        // N-th consecutive differing sample accepts the new level
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_db <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;  // bounce back to the accepted level restarts the count
      end
      btn_db_d <= btn_db;
      press    <= btn_db & ~btn_db_d;
    end
  end

  // ---------------- run FSM ----------------
  state_t            state, state_nxt;
  logic [TO_W-1:0]   to_cnt, to_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              fault_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      to_cnt      <= '0;
      cycle_count <= '0;
      fault       <= 1'b0;
      start       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      to_cnt      <= to_nxt;
      cycle_count <= cnt_nxt;
      fault       <= fault_nxt;
      // outputs are registered decodes of the next state so they move with it
      start       <= (state_nxt == S_LAUNCH);
      busy        <= (state_nxt == S_LAUNCH) || (state_nxt == S_WAIT_ACK) ||
                     (state_nxt == S_RUNNING);
      done        <= (state_nxt == S_DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    to_nxt    = to_cnt;
    cnt_nxt   = cycle_count;
    fault_nxt = fault;
    case (state)
      S_IDLE: begin
        if (press) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!stopped) begin
          state_nxt = S_RUNNING;
        end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
          // this is the ACK_TIMEOUT-th cycle still stopped
          state_nxt = S_DONE;
          fault_nxt = 1'b1;
        end else begin
          to_nxt = to_cnt + TO_W'(1);
        end
      end
      S_RUNNING: begin
        if (stopped) begin
          // halt wins over the watchdog; the halting cycle is not counted
          state_nxt = S_DONE;
          fault_nxt = 1'b0;
`ifdef RUN_WATCHDOG_EN
        end else if (cycle_count == CNT_W'(WDOG_CYCLES)) begin
          state_nxt = S_DONE;
          fault_nxt = 1'b1;
`endif
        end else if (cycle_count != {CNT_W{1'b1}}) begin
          cnt_nxt = cycle_count + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (press) state_nxt = S_LAUNCH;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // clearing on LAUNCH entry makes the cleared values visible during LAUNCH
    if (state_nxt == S_LAUNCH) begin
      cnt_nxt   = '0;
      fault_nxt = 1'b0;
      to_nxt    = '0;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: randomized button presses and core behaviour,
// expected start/done events queued by the stimulus and checked by a monitor.
module tb_cpu_run_ctrl;

  localparam int D    = 16;
  localparam int CW   = 8;
  localparam int T    = 8;
  localparam int W    = 100;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_in = 1'b0;
  logic          stopped = 1'b1;
  logic          start, busy, done, fault;
  logic [CW-1:0] cycle_count;

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(CW),
    .ACK_TIMEOUT(T),
    .WDOG_CYCLES(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .stopped(stopped),
    .start(start),
    .busy(busy),
    .done(done),
    .fault(fault),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int cyc;
    int fault;
    int cnt;
  } done_exp_t;

  int        exp_start_q[$];
  done_exp_t exp_done_q[$];
  int        run_a = 0;
  int        run_r = 0;
  bit        core_active = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Run outcome from the core behaviour: a = cycles stopped stays high after
  // start, then stopped is low for r+1 cycles (first one is the ack cycle).
  function automatic done_exp_t model(input int L, input int a, input int r);
    done_exp_t e;
    int eff;
    if (a >= T) begin
      e.cyc   = L + 1 + T;
      e.fault = 1;
      e.cnt   = 0;
    end else begin
      eff     = r;
      e.fault = 0;
`ifdef RUN_WATCHDOG_EN
      if (r > W) begin
        eff     = W;
        e.fault = 1;
      end
`endif
      e.cnt = (eff > CMAX) ? CMAX : eff;
      e.cyc = L + a + 3 + eff;
    end
    return e;
  endfunction

  // Monitor: pops expectations whenever the DUT presents start or a done rise.
  logic start_d = 1'b0;
  logic done_d  = 1'b0;
  always @(negedge clk) begin
    if (start) begin
      chk("start_single_cycle", int'(start_d), 0);
      if (exp_start_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_start: start high at cycle %0d, none expected", cyc);
      end else begin
        chk("start_cycle", cyc, exp_start_q.pop_front());
        chk("launch_busy", int'(busy), 1);
        chk("launch_done_clr", int'(done), 0);
        chk("launch_fault_clr", int'(fault), 0);
        chk("launch_count_clr", int'(cycle_count), 0);
      end
    end
    if (done && !done_d) begin
      if (exp_done_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: done rose at cycle %0d, none expected", cyc);
      end else begin
        done_exp_t e;
        e = exp_done_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_fault", int'(fault), e.fault);
        chk("done_count", int'(cycle_count), e.cnt);
        chk("done_busy", int'(busy), 0);
      end
    end
    start_d = start;
    done_d  = done;
  end

  // Core model: reacts to start with the currently programmed behaviour.
  always begin
    @(negedge clk);
    if (start) begin
      int L, a, r;
      L = cyc;
      a = run_a;
      r = run_r;
      exp_done_q.push_back(model(L, a, r));
      core_active = 1'b1;
      for (int j = 1; j < 5000; j++) begin
        @(negedge clk);
        if (!busy) break;
        stopped = (j <= a) ? 1'b1 : ((j <= a + 1 + r) ? 1'b0 : 1'b1);
      end
      stopped     = 1'b1;
      core_active = 1'b0;
    end
  end

  // Called at a negedge; optional bounces, then a stable high long enough to
  // be accepted, released just after start is expected.
  task automatic press(input int bounces, input bit expect_start);
    for (int b = 0; b < bounces; b++) begin
      btn_in = 1'b1;
      repeat ($urandom_range(1, D - 3)) @(negedge clk);
      btn_in = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    btn_in = 1'b1;
    if (expect_start) exp_start_q.push_back(cyc + D + 4);
    repeat (D + 5) @(negedge clk);
    btn_in = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_start_q.size() != 0 || exp_done_q.size() != 0 || core_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      fails++;
      $display("FAIL wait_idle: pending after %0d cycles (start_q=%0d done_q=%0d)",
               budget, exp_start_q.size(), exp_done_q.size());
      exp_start_q.delete();
      exp_done_q.delete();
    end
    repeat (D + 6) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, int'(start), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_count"}, int'(cycle_count), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // clean press, ack after one cycle, 37 counted cycles
    run_a = 0; run_r = 37;
    press(0, 1'b1);
    wait_idle(400);

    // bouncing press issued from DONE
    run_a = 2; run_r = $urandom_range(5, 60);
    press(4, 1'b1);
    wait_idle(400);

    // core never acknowledges
    run_a = T + 5; run_r = 10;
    press(1, 1'b1);
    wait_idle(400);

    // long run: saturation, or watchdog when built in
    run_a = 1; run_r = 300;
    press(0, 1'b1);
    wait_idle(800);

    // second press during RUNNING is ignored
    run_a = 0; run_r = 150;
    press(0, 1'b1);
    repeat (10) @(negedge clk);
    press(2, 1'b0);
    wait_idle(400);

    // randomized runs
    for (int i = 0; i < 8; i++) begin
      run_a = $urandom_range(0, T + 2);
      run_r = $urandom_range(0, 130);
      press($urandom_range(0, 3), 1'b1);
      wait_idle(800);
    end

    // reset in the middle of a run
    run_a = 0; run_r = 200;
    press(0, 1'b1);
    n = 0;
    while (cycle_count != CW'(20) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      fails++;
      $display("FAIL midrun_wait: cycle_count never reached 20 (got %0d)", cycle_count);
    end
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midrun_reset");
    reset = 1'b0;
    exp_done_q.delete();
    repeat (60) @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_count", int'(cycle_count), 0);

    // button held through reset counts as a fresh press after release
    run_a = 1; run_r = 5;
    btn_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_start_q.push_back(cyc + D + 5);
    @(negedge clk);
    reset = 1'b0;
    repeat (D + 6) @(negedge clk);
    btn_in = 1'b0;
    wait_idle(400);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
